// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache controller.
// Stalls the pipeline on misses and moves whole lines to/from a slow memory.
module dcache_ctrl #(
    parameter int INDEX_W  = 5,
    parameter int OFFSET_W = 5,
    parameter int CNT_W    = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cpu_req_i,
    input  logic                         cpu_we_i,
    input  logic [31:0]                  cpu_addr_i,
    input  logic [31:0]                  cpu_wdata_i,
    output logic [31:0]                  cpu_rdata_o,
    output logic                         cpu_stall_o,
    output logic                         mem_enable_o,
    output logic                         mem_write_o,
    output logic [31:0]                  mem_addr_o,
    output logic [(8<<OFFSET_W)-1:0]     mem_data_o,
    input  logic [(8<<OFFSET_W)-1:0]     mem_data_i,
    input  logic                         mem_ack_i,
    output logic [CNT_W-1:0]             hit_cnt_o,
    output logic [CNT_W-1:0]             miss_cnt_o
);

    // state     | meaning
    // IDLE      | serve hits, detect misses
    // WRITEBACK | dirty victim line being written to memory
    // REFILL    | requested line being fetched from memory
    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    localparam int TAG_W  = 32 - INDEX_W - OFFSET_W;
    localparam int LINES  = 1 << INDEX_W;
    localparam int LINE_W = 8 << OFFSET_W;
    localparam int WORD_W = OFFSET_W - 2;

    state_t                 state;
    logic [LINES-1:0]       valid_q;
    logic [LINES-1:0]       dirty_q;
    logic [TAG_W-1:0]       tag_q  [LINES];
    logic [LINE_W-1:0]      data_q [LINES];
    logic [CNT_W-1:0]       hit_cnt;
    logic [CNT_W-1:0]       miss_cnt;

    logic [TAG_W-1:0]       cpu_tag;
    logic [INDEX_W-1:0]     cpu_index;
    logic [WORD_W-1:0]      cpu_word;
    logic                   hit;
    logic                   idle_hit;
    logic [31:0]            sel_word;
    logic                   unused_addr;

    assign cpu_tag     = cpu_addr_i[31 -: TAG_W];
    assign cpu_index   = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign cpu_word    = cpu_addr_i[2 +: WORD_W];
    assign unused_addr = ^cpu_addr_i[1:0];

    assign hit      = cpu_req_i & valid_q[cpu_index] & (tag_q[cpu_index] == cpu_tag);
    assign idle_hit = (state == IDLE) & hit;
    assign sel_word = data_q[cpu_index][{cpu_word, 5'd0} +: 32];

    // The stall term is gated by reset so every output reads 0 while held in reset.
    assign cpu_stall_o  = rst_i & ((state != IDLE) | (cpu_req_i & ~hit));
    assign cpu_rdata_o  = (idle_hit & ~cpu_we_i) ? sel_word : 32'd0;
    assign mem_enable_o = (state != IDLE);
    assign mem_write_o  = (state == WRITEBACK);
    assign mem_data_o   = (state == WRITEBACK) ? data_q[cpu_index] : '0;
    assign hit_cnt_o    = hit_cnt;
    assign miss_cnt_o   = miss_cnt;

    always_comb begin
        mem_addr_o = 32'd0;
        case (state)
            WRITEBACK: mem_addr_o = {tag_q[cpu_index], cpu_index, {OFFSET_W{1'b0}}};
            REFILL:    mem_addr_o = {cpu_tag, cpu_index, {OFFSET_W{1'b0}}};
            default:   mem_addr_o = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            valid_q  <= '0;
            dirty_q  <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_req_i) begin
                        if (hit) begin
                            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
                            if (cpu_we_i) dirty_q[cpu_index] <= 1'b1;
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
                            if (valid_q[cpu_index] & dirty_q[cpu_index]) state <= WRITEBACK;
                            else                                         state <= REFILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) state <= REFILL;
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        valid_q[cpu_index] <= 1'b1;
                        dirty_q[cpu_index] <= 1'b0;
                        state              <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line storage has no reset; validity alone decides whether contents are used.
    always_ff @(posedge clk_i) begin
        if (idle_hit & cpu_we_i) begin
            data_q[cpu_index][{cpu_word, 5'd0} +: 32] <= cpu_wdata_i;
        end else if ((state == REFILL) & mem_ack_i) begin
            data_q[cpu_index] <= mem_data_i;
            tag_q[cpu_index]  <= cpu_tag;
        end
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized bench for dcache_ctrl against a line-level cache/memory model.
module tb_dcache_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_we_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_wdata_i;
    logic [31:0]  cpu_rdata_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic [15:0]  hit_cnt_o;
    logic [15:0]  miss_cnt_o;

    always #5 clk_i = ~clk_i;

    dcache_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .cpu_req_i    (cpu_req_i),
        .cpu_we_i     (cpu_we_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_wdata_i  (cpu_wdata_i),
        .cpu_rdata_o  (cpu_rdata_o),
        .cpu_stall_o  (cpu_stall_o),
        .mem_enable_o (mem_enable_o),
        .mem_write_o  (mem_write_o),
        .mem_addr_o   (mem_addr_o),
        .mem_data_o   (mem_data_o),
        .mem_data_i   (mem_data_i),
        .mem_ack_i    (mem_ack_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: cache lines plus a backing store keyed by line address.
    bit           mvalid [32];
    bit           mdirty [32];
    logic [21:0]  mtag   [32];
    logic [255:0] mline  [32];
    logic [255:0] mem_model [logic [31:0]];
    int unsigned  hit_exp;
    int unsigned  miss_exp;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat_inc(input int unsigned v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    function automatic logic [255:0] mem_default(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++)
            l[w*32 +: 32] = a * 32'h9E37_79B9 + w * 32'h0101_0101 + 32'h5A5A_0000;
        return l;
    endfunction

    function automatic logic [255:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return mem_default(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mvalid[i] = 1'b0;
            mdirty[i] = 1'b0;
        end
        hit_exp  = 0;
        miss_exp = 0;
    endtask

    // Entered at posedge+2 of the first cycle of a memory phase; leaves at posedge+2 after the ack edge.
    task automatic mem_phase(input bit wr, input logic [31:0] ea, input logic [255:0] ed, input int delay);
        int d;
        d = (delay < 0) ? int'($urandom_range(0, 4)) : delay;
        for (int c = 0; c <= d; c++) begin
            chk("mem_enable", {255'd0, mem_enable_o}, 256'd1);
            chk("mem_write", {255'd0, mem_write_o}, {255'd0, wr});
            chk("mem_addr", {224'd0, mem_addr_o}, {224'd0, ea});
            chk("stall_mem", {255'd0, cpu_stall_o}, 256'd1);
            if (wr) chk("wb_data", mem_data_o, ed);
            else    chk("mem_data_idle", mem_data_o, 256'd0);
            mem_data_i = wr ? 256'd0 : ed;
            if (c == d) mem_ack_i = 1'b1;
            @(posedge clk_i);
            #1;
            mem_ack_i  = 1'b0;
            mem_data_i = {8{$urandom()}};
            #1;
        end
    endtask

    // Starts and ends at posedge+1.
    task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wd, input int delay);
        logic [4:0]   idx;
        logic [21:0]  tag;
        int           w;
        bit           is_hit;
        logic [31:0]  la;
        logic [31:0]  va;
        logic [255:0] line;
        idx = addr[9:5];
        tag = addr[31:10];
        w   = int'(addr[4:2]);
        cpu_req_i   = 1'b1;
        cpu_we_i    = we;
        cpu_addr_i  = addr;
        cpu_wdata_i = wd;
        #1;
        is_hit = mvalid[idx] && (mtag[idx] == tag);
        chk("stall_first", {255'd0, cpu_stall_o}, {255'd0, !is_hit});
        if (!is_hit) begin
            miss_exp = sat_inc(miss_exp);
            @(posedge clk_i);
            #2;
            if (mvalid[idx] && mdirty[idx]) begin
                va = {mtag[idx], idx, 5'd0};
                mem_phase(1'b1, va, mline[idx], delay);
                mem_model[va] = mline[idx];
            end
            la   = {tag, idx, 5'd0};
            line = mem_read(la);
            mem_phase(1'b0, la, line, delay);
            mline[idx]  = line;
            mtag[idx]   = tag;
            mvalid[idx] = 1'b1;
            mdirty[idx] = 1'b0;
            chk("stall_after_fill", {255'd0, cpu_stall_o}, 256'd0);
        end
        if (!we) chk("rdata", {224'd0, cpu_rdata_o}, {224'd0, mline[idx][w*32 +: 32]});
        else     chk("no_mem_on_hit", {255'd0, mem_enable_o}, 256'd0);
        @(posedge clk_i);
        hit_exp = sat_inc(hit_exp);
        if (we) begin
            mline[idx][w*32 +: 32] = wd;
            mdirty[idx] = 1'b1;
        end
        #1;
        cpu_req_i = 1'b0;
        cpu_we_i  = 1'b0;
        #1;
        chk("hit_cnt", {240'd0, hit_cnt_o}, 256'(hit_exp));
        chk("miss_cnt", {240'd0, miss_cnt_o}, 256'(miss_exp));
        chk("rdata_idle", {224'd0, cpu_rdata_o}, 256'd0);
        chk("mem_addr_idle", {224'd0, mem_addr_o}, 256'd0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [255:0] l40;
        logic [31:0]  ra;
        rst_i       = 1'b0;
        cpu_req_i   = 1'b0;
        cpu_we_i    = 1'b0;
        cpu_addr_i  = 32'd0;
        cpu_wdata_i = 32'd0;
        mem_data_i  = 256'd0;
        mem_ack_i   = 1'b0;
        model_reset();
        #1;
        chk("rst_stall", {255'd0, cpu_stall_o}, 256'd0);
        chk("rst_mem_enable", {255'd0, mem_enable_o}, 256'd0);
        chk("rst_hit_cnt", {240'd0, hit_cnt_o}, 256'd0);
        chk("rst_miss_cnt", {240'd0, miss_cnt_o}, 256'd0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // Directed walk: cold miss, store hit, dirty conflict, clean conflict.
        l40 = mem_default(32'h40);
        l40[31:0] = 32'hDEAD_BEEF;
        mem_model[32'h40] = l40;
        access(1'b0, 32'h0000_0040, 32'd0, 5);
        chk("first_hit_cnt", {240'd0, hit_cnt_o}, 256'd1);
        chk("first_miss_cnt", {240'd0, miss_cnt_o}, 256'd1);
        access(1'b1, 32'h0000_0044, 32'h1234_5678, -1);
        access(1'b0, 32'h0000_0044, 32'd0, -1);
        access(1'b0, 32'h0000_0440, 32'd0, 2);
        chk("wb_word1", mem_model[32'h40][63:32], 256'h1234_5678);
        access(1'b0, 32'h0000_0040, 32'd0, 0);

        // Reset in the middle of a clean refill.
        cpu_req_i  = 1'b1;
        cpu_we_i   = 1'b0;
        cpu_addr_i = 32'h0000_0080;
        @(posedge clk_i);
        #2;
        chk("pre_abort_enable", {255'd0, mem_enable_o}, 256'd1);
        rst_i = 1'b0;
        #1;
        chk("abort_enable", {255'd0, mem_enable_o}, 256'd0);
        chk("abort_stall", {255'd0, cpu_stall_o}, 256'd0);
        chk("abort_miss_cnt", {240'd0, miss_cnt_o}, 256'd0);
        cpu_req_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        access(1'b0, 32'h0000_0080, 32'd0, -1);

        // Random traffic over a few tags and indices to force conflicts.
        for (int i = 0; i < 400; i++) begin
            ra = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 5) |
                 (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), ra, $urandom(), -1);
        end

        // Counter saturation.
        force dut.miss_cnt = 16'hFFFF;
        force dut.hit_cnt  = 16'hFFFF;
        #1;
        release dut.miss_cnt;
        release dut.hit_cnt;
        miss_exp = 65535;
        hit_exp  = 65535;
        @(posedge clk_i);
        #1;
        access(1'b0, 32'h0010_0000, 32'd0, -1);
        access(1'b1, 32'h0020_0004, 32'hCAFE_F00D, -1);
        chk("miss_sat", {240'd0, miss_cnt_o}, 256'hFFFF);
        chk("hit_sat", {240'd0, hit_cnt_o}, 256'hFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
